// File: rtl/mlp_test_sequencer_if.sv
// MLP classifier start/done handshake plus golden-label memory read port.
// The sequencer connects through master; the MLP/label model side through slave.
interface mlp_test_sequencer_if #(
  parameter int unsigned TEST_W = 10,
  parameter int unsigned CLS_W  = 4
);
  logic              mlp_start;
  logic [TEST_W-1:0] mlp_test_num;
  logic              mlp_done;
  logic [CLS_W-1:0]  mlp_out;
  logic [TEST_W-1:0] label_addr;
  logic [CLS_W-1:0]  label_data;

  modport master (
    output mlp_start, mlp_test_num, label_addr,
    input  mlp_done, mlp_out, label_data
  );

  modport slave (
    input  mlp_start, mlp_test_num, label_addr,
    output mlp_done, mlp_out, label_data
  );
endinterface

// File: rtl/mlp_test_sequencer.sv
// Sweeps a range of MLP test vectors, scoring predictions against golden labels.
// Optional per-inference watchdog enabled by defining MLP_SEQ_TIMEOUT_EN.
module mlp_test_sequencer #(
  parameter int unsigned TEST_W      = 10,
  parameter int unsigned CLS_W       = 4,
  parameter int unsigned TIMEOUT_CYC = 8192
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 run,
  input  logic [TEST_W-1:0]    first_test,
  input  logic [TEST_W-1:0]    num_tests,
  mlp_test_sequencer_if.master bus,
  output logic                 busy,
  output logic                 finished,
  output logic [TEST_W-1:0]    tested_cnt,
  output logic [TEST_W-1:0]    correct_cnt,
  output logic [CLS_W-1:0]     last_pred,
  output logic                 timeout_err
);

  typedef enum logic [2:0] {
    S_IDLE, S_ISSUE, S_WAIT, S_CHECK, S_NEXT, S_FINISH
  } state_t;

  localparam logic [TEST_W-1:0] CNT_MAX = '1;

  state_t            state;
  logic [TEST_W-1:0] idx;
  logic [TEST_W-1:0] remaining;
  logic [CLS_W-1:0]  pred_r;
  logic              done_q;
  logic              done_edge;
  logic              start_r;

  // A zero watchdog limit would time out every inference immediately.
  if (TIMEOUT_CYC == 0) begin : g_bad_timeout
    $error("TIMEOUT_CYC must be non-zero");
  end

  function automatic logic [TEST_W-1:0] sat_inc(input logic [TEST_W-1:0] v);
    return (v == CNT_MAX) ? v : v + TEST_W'(1);
  endfunction

  // A done level left high from the previous inference never re-triggers.
  assign done_edge        = bus.mlp_done & ~done_q;
  assign bus.mlp_start    = start_r;
  assign bus.mlp_test_num = idx;
  assign bus.label_addr   = idx;

`ifdef MLP_SEQ_TIMEOUT_EN
  localparam int unsigned WD_W = $clog2(TIMEOUT_CYC) + 1;

  logic [WD_W-1:0] wd_cnt;
  logic            wd_expired;

  assign wd_expired = (wd_cnt == WD_W'(TIMEOUT_CYC - 1));

  // Watchdog: cleared while issuing, counts WAIT cycles.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wd_cnt <= '0;
    end else if (state == S_ISSUE) begin
      wd_cnt <= '0;
    end else if (state == S_WAIT) begin
      wd_cnt <= wd_cnt + WD_W'(1);
    end
  end
`endif

  // Sequencer FSM with registered outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= S_IDLE;
      idx         <= '0;
      remaining   <= '0;
      pred_r      <= '0;
      done_q      <= 1'b0;
      start_r     <= 1'b0;
      busy        <= 1'b0;
      finished    <= 1'b0;
      tested_cnt  <= '0;
      correct_cnt <= '0;
      last_pred   <= '0;
      timeout_err <= 1'b0;
    end else begin
      done_q  <= bus.mlp_done;
      start_r <= 1'b0;
      case (state)
        S_IDLE, S_FINISH: begin
          if (run) begin
            idx         <= first_test;
            remaining   <= num_tests;
            tested_cnt  <= '0;
            correct_cnt <= '0;
            last_pred   <= '0;
            timeout_err <= 1'b0;
            if (num_tests == '0) begin
              state    <= S_FINISH;
              busy     <= 1'b0;
              finished <= 1'b1;
            end else begin
              state    <= S_ISSUE;
              start_r  <= 1'b1;
              busy     <= 1'b1;
              finished <= 1'b0;
            end
          end
        end
        S_ISSUE: state <= S_WAIT;
        S_WAIT: begin
          if (done_edge) begin
            pred_r    <= bus.mlp_out;
            last_pred <= bus.mlp_out;
            state     <= S_CHECK;
          end
`ifdef MLP_SEQ_TIMEOUT_EN
          else if (wd_expired) begin
            timeout_err <= 1'b1;
            tested_cnt  <= sat_inc(tested_cnt);
            last_pred   <= '0;
            state       <= S_NEXT;
          end
`endif
        end
        S_CHECK: begin
          tested_cnt <= sat_inc(tested_cnt);
          if (pred_r == bus.label_data) begin
            correct_cnt <= sat_inc(correct_cnt);
          end
          state <= S_NEXT;
        end
        S_NEXT: begin
          remaining <= remaining - TEST_W'(1);
          idx       <= idx + TEST_W'(1);
          if (remaining == TEST_W'(1)) begin
            state    <= S_FINISH;
            busy     <= 1'b0;
            finished <= 1'b1;
          end else begin
            state   <= S_ISSUE;
            start_r <= 1'b1;
          end
        end
        default: begin
          state    <= S_IDLE;
          busy     <= 1'b0;
          finished <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/mlp_test_sequencer.md
Name: mlp_test_sequencer

Overview:
- Host-side initiator for the MLP classifier core's start/done handshake.
- Walks a contiguous range of test-vector indices:
  - drives mlp_start and mlp_test_num;
  - waits for mlp_done;
  - captures the 4-bit predicted class;
  - compares it with the golden label from an external label memory.
- Accumulates tested and correct counts for on-board accuracy measurement.
- Sits beside the MLP top at SoC/testbench level; a single run pulse benchmarks a whole test set.

Parameters:
- TEST_W, 10, width of test index / mlp_test_num
- CLS_W, 4, width of class prediction and label
- TIMEOUT_CYC, 8192, per-inference watchdog limit (used only with the optional feature)

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-low reset
- run  in  1  one-cycle pulse: start a sweep (ignored unless state IDLE or FINISH)
- first_test  in  TEST_W  first index of sweep, sampled on run
- num_tests  in  TEST_W  number of inferences, sampled on run; 0 means no inference (straight to FINISH)
- mlp_start  out  1  one-cycle start pulse to MLP
- mlp_test_num  out  TEST_W  index presented to MLP, stable from ISSUE until CHECK completes
- mlp_done  in  1  MLP completion; pulse or level accepted, rising edge detected
- mlp_out  in  CLS_W  MLP prediction, valid in the cycle mlp_done rises
- label_addr  out  TEST_W  label memory address, equals mlp_test_num
- label_data  in  CLS_W  combinational label read of label_addr
- busy  out  1  high in ISSUE/WAIT/CHECK/NEXT
- finished  out  1  high in FINISH, held until next run
- tested_cnt  out  TEST_W  inferences completed this sweep
- correct_cnt  out  TEST_W  predictions equal to label this sweep
- last_pred  out  CLS_W  most recent captured prediction
- timeout_err  out  1  sticky watchdog flag (0 when feature compiled out)

Behaviour:
- Reset values: all outputs 0, state IDLE, internal done_q=0.
- mlp_done edge detector:
  - done_q registers mlp_done every cycle;
  - edge = mlp_done & ~done_q;
  - a done level still high from the previous inference therefore never re-triggers.
- IDLE/FINISH + run:
  - load idx=first_test, remaining=num_tests;
  - clear tested_cnt, correct_cnt, last_pred, timeout_err;
  - go to ISSUE, or to FINISH if num_tests==0.
- ISSUE: mlp_start=1 for exactly this cycle; mlp_test_num=label_addr=idx; go WAIT.
- WAIT:
  - on edge: capture mlp_out into pred_r and last_pred; go CHECK;
  - otherwise hold.
  - An edge in the ISSUE cycle itself is ignored.
- CHECK (1 cycle):
  - tested_cnt+1;
  - correct_cnt+1 iff pred_r==label_data;
  - go NEXT.
- NEXT:
  - remaining-1 and idx+1;
  - idx wraps modulo 2^TEST_W, e.g. 1023 -> 0;
  - if remaining becomes 0 go FINISH, else ISSUE.
- FINISH: finished=1; counters frozen.
- Latency per inference: 1 (ISSUE) + MLP latency + 1 (edge capture) + 2 (CHECK, NEXT) cycles between successive mlp_start pulses.
- Counters saturate at all-ones; they never wrap.
- run while busy: ignored, no effect on counters or state.
- Reset mid-sweep (rst low at any time): immediate return to reset values. mlp_start deasserts asynchronously.

Optional Feature:
- Macro: MLP_SEQ_TIMEOUT_EN.
- With macro:
  - a watchdog counter clears on entering WAIT and counts while in WAIT;
  - on reaching TIMEOUT_CYC without an edge: set timeout_err (sticky until next run), count the inference as tested but not correct, last_pred=0, go NEXT.
- Without macro: WAIT holds indefinitely; timeout_err tied 0; no counter logic synthesized.

Test Plan:
- Basic sweep:
  - Stimulus: run with first_test=0, num_tests=4; model MLP answers done pulse after 10 cycles with out=idx[3:0]; labels {0,1,5,3}.
  - Response: exactly 4 one-cycle mlp_start pulses with test_num 0,1,2,3; tested_cnt=4, correct_cnt=3, last_pred=3, finished=1.
- Level-held done:
  - Stimulus: model holds done high until its next start; labels equal predictions; first_test=7, num_tests=3.
  - Response: exactly 3 starts; correct_cnt=3; no double counting.
- Wrap and zero length:
  - Stimulus: first_test=1022, num_tests=3, then a separate run with num_tests=0.
  - Response: test_num sequence 1022,1023,0; second run gives finished within 1 cycle, counters 0, no mlp_start.
- Reset and run while busy:
  - Stimulus: run pulsed again during WAIT; then rst low during second inference.
  - Response: second run has no effect; after reset all outputs 0, state IDLE; a fresh run restarts from first_test.
- Timeout (MLP_SEQ_TIMEOUT_EN, TIMEOUT_CYC=16):
  - Stimulus: model never asserts done for idx 2 of a 4-test sweep.
  - Response: timeout_err=1; tested_cnt=4; correct_cnt excludes idx 2; sweep completes to finished.
